// File: rtl/stack_ctrl.sv
// stack_ctrl: push/pop stack sequencer for a registered byte memory; STACK_GUARD_EN enables overflow/underflow blocking and sticky err
module stack_ctrl #(
  parameter int ADDRWIDTH = 3,
  parameter int SP_INIT = 2**ADDRWIDTH-1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [7:0]           push_data,
  output logic                 ready,
  output logic [7:0]           pop_data,
  output logic                 pop_valid,
  output logic [ADDRWIDTH-1:0] sp,
  output logic                 full,
  output logic                 empty,
  output logic                 err,
  output logic                 mem_cs,
  output logic                 mem_rw,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [7:0]           mem_din,
  input  logic [7:0]           mem_dout
);
  localparam int DEPTH = 2**ADDRWIDTH;
  typedef enum logic [1:0] {IDLE, PUSH_WR, POP_RD, POP_CAP} state_t;
  state_t state;
  logic [ADDRWIDTH:0] count;
  logic push_blk, pop_blk;
  assign ready = state == IDLE;
  assign full = count == (ADDRWIDTH+1)'(DEPTH);
  assign empty = count == '0;
`ifdef STACK_GUARD_EN
  assign push_blk = full;
  assign pop_blk = empty;
`else
  assign push_blk = 1'b0;
  assign pop_blk = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      sp <= ADDRWIDTH'(SP_INIT);
      mem_cs <= 1'b1;
      mem_rw <= 1'b1;
      mem_addr <= '0;
      mem_din <= '0;
      pop_data <= '0;
      pop_valid <= 1'b0;
`ifdef STACK_GUARD_EN
      err <= 1'b0;
`endif
    end else begin
      pop_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (push && !push_blk) begin
            sp <= sp + 1'b1;
            mem_addr <= sp + 1'b1;
            mem_din <= push_data;
            mem_cs <= 1'b0;
            mem_rw <= 1'b0;
            count <= full ? count : count + 1'b1;
            state <= PUSH_WR;
          end else if (!push && pop && !pop_blk) begin
            mem_addr <= sp;
            mem_cs <= 1'b0;
            mem_rw <= 1'b1;
            state <= POP_RD;
          end
`ifdef STACK_GUARD_EN
          if ((push && push_blk) || (!push && pop && pop_blk)) err <= 1'b1;
`endif
        end
        PUSH_WR: begin
          mem_cs <= 1'b1;
          mem_rw <= 1'b1;
          state <= IDLE;
        end
        POP_RD: begin
          sp <= sp - 1'b1;
          count <= empty ? count : count - 1'b1;
          state <= POP_CAP;
        end
        default: begin
          pop_data <= mem_dout;
          pop_valid <= 1'b1;
          mem_cs <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed self-checking bench for stack_ctrl with a registered byte memory model
module tb_stack_ctrl;
  logic clk, rst, push, pop, ready, pop_valid, full, empty, err, mem_cs, mem_rw;
  logic [7:0] push_data, pop_data, mem_din;
  logic [7:0] mem_dout = '0;
  logic [2:0] sp, mem_addr;
  logic [7:0] mem [8];
  logic [7:0] d;
  logic v;
  int total = 0, bad = 0;

  stack_ctrl dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .ready(ready), .pop_data(pop_data), .pop_valid(pop_valid), .sp(sp),
    .full(full), .empty(empty), .err(err), .mem_cs(mem_cs), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!mem_cs) begin
      if (!mem_rw) mem[mem_addr] <= mem_din;
      else mem_dout <= mem[mem_addr];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] b);
    push = 1'b1;
    push_data = b;
    step;
    push = 1'b0;
    step;
  endtask

  task automatic do_pop(output logic [7:0] b, output logic vv);
    pop = 1'b1;
    step;
    pop = 1'b0;
    step;
    step;
    b = pop_data;
    vv = pop_valid;
  endtask

  initial begin
    logic [7:0] exp_pop [3];
    exp_pop[0] = 8'h33;
    exp_pop[1] = 8'h22;
    exp_pop[2] = 8'h11;
    rst = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    push_data = '0;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_sp", sp, 7);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_cs", mem_cs, 1);
    chk("rst_rw", mem_rw, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_pdata", pop_data, 0);
    chk("rst_pvalid", pop_valid, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    push = 1'b1;
    push_data = 8'hA5;
    step;
    push = 1'b0;
    chk("p1_cs", mem_cs, 0);
    chk("p1_rw", mem_rw, 0);
    chk("p1_addr", mem_addr, 0);
    chk("p1_din", mem_din, 8'hA5);
    chk("p1_sp", sp, 0);
    chk("p1_empty", empty, 0);
    chk("p1_ready", ready, 0);
    step;
    chk("p1_cs_off", mem_cs, 1);
    chk("p1_ready_back", ready, 1);
    chk("p1_mem", mem[0], 8'hA5);
    do_rst;
    do_push(8'h11);
    do_push(8'h22);
    do_push(8'h33);
    chk("lifo_sp", sp, 2);
    pop = 1'b1;
    step;
    pop = 1'b0;
    chk("pop_cs", mem_cs, 0);
    chk("pop_rw", mem_rw, 1);
    chk("pop_addr", mem_addr, 2);
    chk("pop_ready", ready, 0);
    step;
    chk("pop_v_early", pop_valid, 0);
    chk("pop_sp_dec", sp, 1);
    step;
    chk("lifo_v0", pop_valid, 1);
    chk("lifo_d0", pop_data, exp_pop[0]);
    chk("lifo_rdy0", ready, 1);
    for (int i = 1; i < 3; i++) begin
      do_pop(d, v);
      chk("lifo_v", v, 1);
      chk("lifo_d", d, exp_pop[i]);
    end
    step;
    chk("lifo_v_drop", pop_valid, 0);
    chk("lifo_hold", pop_data, 8'h11);
    chk("lifo_sp_end", sp, 7);
    chk("lifo_empty", empty, 1);
    do_rst;
    for (int i = 0; i < 8; i++) do_push(8'(i));
    chk("fill_full", full, 1);
    chk("fill_sp", sp, 7);
    push = 1'b1;
    push_data = 8'h08;
    step;
    push = 1'b0;
`ifdef STACK_GUARD_EN
    chk("ovf_err", err, 1);
    chk("ovf_cs", mem_cs, 1);
    chk("ovf_sp", sp, 7);
    chk("ovf_ready", ready, 1);
`else
    chk("ovf_cs", mem_cs, 0);
    chk("ovf_addr", mem_addr, 0);
    chk("ovf_sp", sp, 0);
    chk("ovf_full", full, 1);
    chk("ovf_err", err, 0);
    step;
    chk("ovf_mem", mem[0], 8'h08);
`endif
    do_rst;
    pop = 1'b1;
    step;
    pop = 1'b0;
`ifdef STACK_GUARD_EN
    chk("unf_err", err, 1);
    chk("unf_cs", mem_cs, 1);
    chk("unf_ready", ready, 1);
    step;
    step;
    chk("unf_pvalid", pop_valid, 0);
    chk("unf_sp", sp, 7);
`else
    chk("unf_cs", mem_cs, 0);
    chk("unf_addr", mem_addr, 7);
    step;
    step;
    chk("unf_pvalid", pop_valid, 1);
    chk("unf_sp", sp, 6);
    chk("unf_empty", empty, 1);
`endif
    do_rst;
    push = 1'b1;
    pop = 1'b1;
    push_data = 8'h5C;
    step;
    push = 1'b0;
    chk("both_rw", mem_rw, 0);
    chk("both_cs", mem_cs, 0);
    chk("both_sp", sp, 0);
    step;
    chk("both_ready", ready, 1);
    step;
    pop = 1'b0;
    chk("both_pop_cs", mem_cs, 0);
    chk("both_pop_rw", mem_rw, 1);
    chk("both_pop_addr", mem_addr, 0);
    step;
    step;
    chk("both_pvalid", pop_valid, 1);
    chk("both_pdata", pop_data, 8'h5C);
    chk("both_sp_end", sp, 7);
    chk("both_empty", empty, 1);
    do_rst;
    push = 1'b1;
    push_data = 8'h99;
    step;
    push = 1'b0;
    chk("mid_cs_pre", mem_cs, 0);
    rst = 1'b1;
    #1;
    chk("mid_cs", mem_cs, 1);
    chk("mid_ready", ready, 1);
    chk("mid_sp", sp, 7);
    chk("mid_empty", empty, 1);
    step;
    rst = 1'b0;
    chk("mid_nowrite", mem[0], 8'h5C);
    step;
    chk("mid_cs_idle", mem_cs, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
